shared_mem_ctrl: RTL and testbench
==================================

Name: shared_mem_ctrl

Overview:
Main-memory responder on the common snoop bus of the 4-core MESI data-cache cluster, directly downstream of the cache/arbiter complex.
- Serves line fills requested by BusRd/BusRdX after a fixed latency.
- Accepts write-backs (Mem_wr) and signals Mem_write_done when the write has committed.
- Honours Mem_oprn_abort when a snooping cache supplies the data instead.
- Replaces the ad-hoc memory stub in the multi-core bench and is synthesizable.

Parameters:
- DEPTH_LOG2, 10: number of 32-bit words = 2**DEPTH_LOG2.
- RD_LATENCY, 4: cycles from read accept to first cycle Data_in_Bus is high; legal range 1..15.
- WR_LATENCY, 4: cycles from write accept to first cycle Mem_write_done is high; legal range 1..15.

Ports:
- clk, input, 1: single clock; all logic on posedge.
- rst, input, 1: synchronous, active-high reset.
- BusRd, input, 1: bus read request; level, held until completion.
- BusRdX, input, 1: bus read-exclusive request; treated identically to BusRd.
- Mem_wr, input, 1: write-back request; level, held until Mem_write_done is seen.
- Mem_oprn_abort, input, 1: cancels an in-flight read.
- Address_Com, input, 32: common bus address; byte address, word index = Address_Com[DEPTH_LOG2+1:2].
- Data_Bus_Com_in, input, 32: write data from the common bus.
- Data_Bus_Com_out, output, 32: read data to the common bus.
- Data_Bus_Com_oe, output, 1: drive enable for the tristate Data_Bus_Com, resolved at top level.
- Data_in_Bus, output, 1: read data valid on the bus.
- Mem_write_done, output, 1: write committed.
- Mem_busy, output, 1: high when state is not IDLE.

Behaviour:
- Reset: state = IDLE. Data_Bus_Com_out, Data_Bus_Com_oe, Data_in_Bus, Mem_write_done and Mem_busy are all 0. Counter = 0. Array contents are not cleared.
- Reset mid-operation: the operation is dropped. A pending write is NOT committed.
- States: IDLE, RD_WAIT, RD_DRIVE, RD_ABORT, WR_WAIT, WR_DONE.
- IDLE accept:
  - Mem_wr has priority over BusRd|BusRdX when both are high.
  - The accept cycle latches the word index, plus Data_Bus_Com_in for writes, and loads counter = latency-1.
  - Go to WR_WAIT or RD_WAIT.
- RD_WAIT:
  - Counter decrements each cycle.
  - Counter==0 -> RD_DRIVE. In RD_DRIVE, Data_in_Bus=1, Data_Bus_Com_oe=1, Data_Bus_Com_out=mem[idx].
  - Resulting timing: request sampled at edge N, Data_in_Bus high from edge N+RD_LATENCY.
  - Mem_oprn_abort=1 -> RD_ABORT.
  - BusRd|BusRdX dropped -> IDLE. Abort has priority over counter expiry.
- RD_DRIVE:
  - Outputs hold until BusRd|BusRdX is low, then IDLE with outputs low on the next edge.
  - Mem_oprn_abort=1 -> outputs drop on the next edge and the FSM enters RD_ABORT.
- RD_ABORT: no outputs driven; return to IDLE once BusRd and BusRdX are both low.
- WR_WAIT:
  - Counter decrements.
  - At 0: mem[idx] <= latched data, state WR_DONE, Mem_write_done=1.
  - Mem_oprn_abort is ignored; write-backs always complete.
  - Mem_wr dropped before completion -> IDLE, no commit.
- WR_DONE: Mem_write_done held until Mem_wr is low, then IDLE.
- Back-to-back: a new request is accepted no earlier than the cycle after returning to IDLE, so the minimum gap is 1 idle cycle.
- Address aliasing: bits above DEPTH_LOG2+1 and bits [1:0] are ignored.
- Read-after-write to the same word returns the new data; the commit precedes the next accept.
- Without the optional feature, a never-written word reads X in simulation and is undefined in synthesis.

Optional Feature:
SHARED_MEM_INIT_PATTERN_EN
- Defined:
  - A per-word valid bit is added; rst clears all valid bits.
  - A read of an invalid word returns {Address_Com[31:2],2'b00} from the latched address.
  - Write commit sets the valid bit.
- Undefined: no valid bits; behaviour as above.

Decomposition:
- Package shared_mem_pkg holds:
  - typedef enum mem_state_t covering the six states.
  - Localparams for word-index MSB/LSB derived from DEPTH_LOG2.
  - Default latencies.
- One sub-module, shared_mem_array: single-port synchronous-write, asynchronous-read word array, plus the optional valid-bit vector. The FSM lives in shared_mem_ctrl.

Test Plan:
1. Write then read:
   - Mem_wr with Address_Com=32'h0000_0040 and data 32'hDEADBEEF -> Mem_write_done high 4 cycles after accept.
   - Then BusRd to the same address -> Data_in_Bus high 4 cycles after accept with Data_Bus_Com_out=32'hDEADBEEF and oe=1.
2. Abort:
   - BusRdX to 32'h0000_0040, then Mem_oprn_abort pulsed 2 cycles after accept -> Data_in_Bus never asserts.
   - Mem_busy stays high until BusRdX drops, then falls the next cycle.
3. Simultaneous requests: Mem_wr and BusRd high in the same IDLE cycle -> write served first (Mem_write_done); the read completes only after Mem_wr drops.
4. Abort during write: Mem_oprn_abort high during WR_WAIT -> write still commits; a subsequent read returns the written value.
5. Reset mid-write: rst asserted at cycle 2 of WR_WAIT -> all outputs 0 on the next edge; a later read of that word shows the old value, not the new one.
6. Aliasing and pattern:
   - With SHARED_MEM_INIT_PATTERN_EN after rst, BusRd to never-written 32'h1000_0104 -> data 32'h1000_0104.
   - After a write of 32'h1234_5678 to 32'h0000_0104, a read of 32'h1000_0104 returns 32'h1234_5678 because the upper bits alias.

Source files
------------

// File: rtl/shared_mem_pkg.sv
// shared_mem_pkg
// Purpose : Shared types and constants for the snoop-bus main-memory responder
//           (shared_mem_ctrl) and its word array (shared_mem_array).
// Contents: mem_state_t FSM encoding, default geometry and latencies,
//           word-index bit positions within a byte address.
// Optional feature macro: SHARED_MEM_INIT_PATTERN_EN (used by the other files).
`timescale 1ns/1ps
package shared_mem_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_WAIT  = 3'd1,
    RD_DRIVE = 3'd2,
    RD_ABORT = 3'd3,
    WR_WAIT  = 3'd4,
    WR_DONE  = 3'd5
  } mem_state_t;

  localparam int DEFAULT_DEPTH_LOG2 = 10;
  localparam int DEFAULT_RD_LATENCY = 4;
  localparam int DEFAULT_WR_LATENCY = 4;

  // Latencies are limited to 1..15, so a 4-bit down-counter suffices.
  localparam int CNT_W = 4;

  // Bus addresses are byte addresses; the word index starts at bit 2.
  localparam int WORD_IDX_LSB = 2;

  function automatic int wordIdxMsb(input int depthLog2);
    return depthLog2 + WORD_IDX_LSB - 1;
  endfunction

endpackage

// File: rtl/shared_mem_array.sv
// shared_mem_array
// Purpose : Single-port word store for shared_mem_ctrl. Synchronous write,
//           asynchronous read, both at the same word index.
// Ports   : clk_i    - clock
//           rst_i    - sync active-high reset, clears valid bits
//                      (only present with SHARED_MEM_INIT_PATTERN_EN)
//           we_i     - write enable
//           idx_i    - word index for read and write
//           wdata_i  - write data
//           rdata_o  - read data at idx_i
//           valid_o  - word at idx_i has been written since reset
//                      (only present with SHARED_MEM_INIT_PATTERN_EN)
// Optional feature macro: SHARED_MEM_INIT_PATTERN_EN adds a per-word valid bit.
`timescale 1ns/1ps
module shared_mem_array
  import shared_mem_pkg::*;
#(
  parameter int DEPTH_LOG2 = DEFAULT_DEPTH_LOG2
) (
  input  logic                  clk_i,
`ifdef SHARED_MEM_INIT_PATTERN_EN
  input  logic                  rst_i,
`endif
  input  logic                  we_i,
  input  logic [DEPTH_LOG2-1:0] idx_i,
  input  logic [31:0]           wdata_i,
`ifdef SHARED_MEM_INIT_PATTERN_EN
  output logic                  valid_o,
`endif
  output logic [31:0]           rdata_o
);

  localparam int WORDS = 2 ** DEPTH_LOG2;

  logic [31:0] mem [WORDS];

  // Storage is deliberately not reset; contents survive rst.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem[idx_i] <= wdata_i;
    end
  end

  assign rdata_o = mem[idx_i];

`ifdef SHARED_MEM_INIT_PATTERN_EN
  logic [WORDS-1:0] valid_q;

  // Valid bits mark words written since the last reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= '0;
    end else if (we_i) begin
      valid_q[idx_i] <= 1'b1;
    end
  end

  assign valid_o = valid_q[idx_i];
`endif

endmodule

// File: rtl/shared_mem_ctrl.sv
// shared_mem_ctrl
// Purpose : Main-memory responder on the 4-core MESI snoop bus. Serves
//           BusRd/BusRdX line fills after RD_LATENCY cycles, commits Mem_wr
//           write-backs after WR_LATENCY cycles, and honours Mem_oprn_abort
//           for reads when a cache supplies the data instead.
// Ports   : clk, rst (sync, active-high)
//           BusRd, BusRdX, Mem_wr, Mem_oprn_abort - level requests / cancel
//           Address_Com      - byte address, word index = [DEPTH_LOG2+1:2]
//           Data_Bus_Com_in  - write data
//           Data_Bus_Com_out - read data, Data_Bus_Com_oe its drive enable
//           Data_in_Bus      - read data valid
//           Mem_write_done   - write committed
//           Mem_busy         - FSM not IDLE
// Optional feature macro: SHARED_MEM_INIT_PATTERN_EN - reads of words not
//           written since reset return {address[31:2],2'b00}.
`timescale 1ns/1ps
module shared_mem_ctrl
  import shared_mem_pkg::*;
#(
  parameter int DEPTH_LOG2 = DEFAULT_DEPTH_LOG2,
  parameter int RD_LATENCY = DEFAULT_RD_LATENCY,
  parameter int WR_LATENCY = DEFAULT_WR_LATENCY
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        BusRd,
  input  logic        BusRdX,
  input  logic        Mem_wr,
  input  logic        Mem_oprn_abort,
  input  logic [31:0] Address_Com,
  input  logic [31:0] Data_Bus_Com_in,
  output logic [31:0] Data_Bus_Com_out,
  output logic        Data_Bus_Com_oe,
  output logic        Data_in_Bus,
  output logic        Mem_write_done,
  output logic        Mem_busy
);

  localparam int IDX_MSB = wordIdxMsb(DEPTH_LOG2);
  localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(RD_LATENCY - 1);
  localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WR_LATENCY - 1);

  mem_state_t            state_q, state_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [DEPTH_LOG2-1:0] idx_q, idx_d;
  logic [31:0]           wrData_q, wrData_d;
  logic                  readReq;
  logic                  memWe;
  logic [31:0]           memRdata;
  logic [31:0]           readData;

  assign readReq = BusRd | BusRdX;

`ifdef SHARED_MEM_INIT_PATTERN_EN
  logic [29:0] addrHi_q, addrHi_d;
  logic        memValid;
  logic        unused_addrBits;

  assign unused_addrBits = ^Address_Com[1:0];
  assign readData = memValid ? memRdata : {addrHi_q, 2'b00};
`else
  logic unused_addrBits;

  assign unused_addrBits = ^{Address_Com[31:IDX_MSB+1], Address_Com[1:0]};
  assign readData = memRdata;
`endif

  // Control state and counter are reset; a reset mid-operation drops it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  // Request payload is only meaningful after an accept, so it needs no reset.
  always_ff @(posedge clk) begin
    idx_q    <= idx_d;
    wrData_q <= wrData_d;
`ifdef SHARED_MEM_INIT_PATTERN_EN
    addrHi_q <= addrHi_d;
`endif
  end

  // Next-state and output decode. Abort outranks both request drop and
  // counter expiry on the read side; the write side ignores abort entirely.
  always_comb begin
    state_d          = state_q;
    count_d          = count_q;
    idx_d            = idx_q;
    wrData_d         = wrData_q;
`ifdef SHARED_MEM_INIT_PATTERN_EN
    addrHi_d         = addrHi_q;
`endif
    memWe            = 1'b0;
    Data_Bus_Com_out = '0;
    Data_Bus_Com_oe  = 1'b0;
    Data_in_Bus      = 1'b0;
    Mem_write_done   = 1'b0;
    Mem_busy         = (state_q != IDLE);

    case (state_q)
      IDLE: begin
        if (Mem_wr || readReq) begin
          idx_d = Address_Com[IDX_MSB:WORD_IDX_LSB];
`ifdef SHARED_MEM_INIT_PATTERN_EN
          addrHi_d = Address_Com[31:2];
`endif
          if (Mem_wr) begin
            state_d  = WR_WAIT;
            count_d  = WR_LOAD;
            wrData_d = Data_Bus_Com_in;
          end else begin
            state_d = RD_WAIT;
            count_d = RD_LOAD;
          end
        end
      end
      RD_WAIT: begin
        if (Mem_oprn_abort) begin
          state_d = RD_ABORT;
        end else if (!readReq) begin
          state_d = IDLE;
        end else if (count_q == '0) begin
          state_d = RD_DRIVE;
        end else begin
          count_d = count_q - 1'b1;
        end
      end
      RD_DRIVE: begin
        Data_in_Bus      = 1'b1;
        Data_Bus_Com_oe  = 1'b1;
        Data_Bus_Com_out = readData;
        if (Mem_oprn_abort) begin
          state_d = RD_ABORT;
        end else if (!readReq) begin
          state_d = IDLE;
        end
      end
      RD_ABORT: begin
        if (!readReq) begin
          state_d = IDLE;
        end
      end
      WR_WAIT: begin
        if (!Mem_wr) begin
          state_d = IDLE;
        end else if (count_q == '0) begin
          // A reset on the commit edge must not let the write land.
          memWe   = ~rst;
          state_d = WR_DONE;
        end else begin
          count_d = count_q - 1'b1;
        end
      end
      WR_DONE: begin
        Mem_write_done = 1'b1;
        if (!Mem_wr) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  shared_mem_array #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_array (
    .clk_i  (clk),
`ifdef SHARED_MEM_INIT_PATTERN_EN
    .rst_i  (rst),
    .valid_o(memValid),
`endif
    .we_i   (memWe),
    .idx_i  (idx_q),
    .wdata_i(wrData_q),
    .rdata_o(memRdata)
  );

endmodule

// File: tb/tb_shared_mem_ctrl.sv
// tb_shared_mem_ctrl
// Purpose : Self-checking bench for shared_mem_ctrl. Directed scenarios
//           (write/read, abort, simultaneous requests, abort during write,
//           reset mid-write, aliasing) followed by randomized traffic,
//           checked against a word-array reference model.
// Optional feature macro: SHARED_MEM_INIT_PATTERN_EN selects the
//           init-pattern expectations for never-written words.
`timescale 1ns/1ps
module tb_shared_mem_ctrl;

  localparam int DEPTH_LOG2 = 10;
  localparam int RD_LAT     = 4;
  localparam int WR_LAT     = 4;
  localparam int WORDS      = 1 << DEPTH_LOG2;
  localparam int MAX_WAIT   = 40;

  logic        clk = 1'b0;
  logic        rst;
  logic        BusRd;
  logic        BusRdX;
  logic        Mem_wr;
  logic        Mem_oprn_abort;
  logic [31:0] Address_Com;
  logic [31:0] Data_Bus_Com_in;
  logic [31:0] Data_Bus_Com_out;
  logic        Data_Bus_Com_oe;
  logic        Data_in_Bus;
  logic        Mem_write_done;
  logic        Mem_busy;

  int checkCount = 0;
  int passCount  = 0;

  logic [31:0] refMem   [WORDS];
  bit          refKnown [WORDS];

  always #5 clk = ~clk;

  shared_mem_ctrl #(
    .DEPTH_LOG2(DEPTH_LOG2),
    .RD_LATENCY(RD_LAT),
    .WR_LATENCY(WR_LAT)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .BusRd           (BusRd),
    .BusRdX          (BusRdX),
    .Mem_wr          (Mem_wr),
    .Mem_oprn_abort  (Mem_oprn_abort),
    .Address_Com     (Address_Com),
    .Data_Bus_Com_in (Data_Bus_Com_in),
    .Data_Bus_Com_out(Data_Bus_Com_out),
    .Data_Bus_Com_oe (Data_Bus_Com_oe),
    .Data_in_Bus     (Data_in_Bus),
    .Mem_write_done  (Mem_write_done),
    .Mem_busy        (Mem_busy)
  );

  // Word index of a byte address: drop the byte offset, wrap to the array size.
  function automatic int wordOf(input logic [31:0] addr);
    return int'((addr / 32'd4) % WORDS);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
  endtask

  task automatic applyStimulus(input logic rd, input logic rdx, input logic wr,
                               input logic ab, input logic [31:0] addr,
                               input logic [31:0] data);
    BusRd           = rd;
    BusRdX          = rdx;
    Mem_wr          = wr;
    Mem_oprn_abort  = ab;
    Address_Com     = addr;
    Data_Bus_Com_in = data;
  endtask

  // Advance past the next rising edge; outputs are sampled 1ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic modelReset();
`ifdef SHARED_MEM_INIT_PATTERN_EN
    for (int i = 0; i < WORDS; i++) refKnown[i] = 1'b0;
`endif
  endtask

  task automatic expectedRead(input logic [31:0] addr, output bit known,
                              output logic [31:0] value);
    known = refKnown[wordOf(addr)];
    value = refMem[wordOf(addr)];
`ifdef SHARED_MEM_INIT_PATTERN_EN
    if (!known) begin
      known = 1'b1;
      value = addr & 32'hFFFF_FFFC;
    end
`endif
  endtask

  task automatic doWrite(input logic [31:0] addr, input logic [31:0] data,
                         input logic abortDuring);
    int cycles;
    applyStimulus(1'b0, 1'b0, 1'b1, abortDuring, addr, data);
    cycles = 0;
    do begin
      tick();
      cycles++;
    end while (!Mem_write_done && cycles < MAX_WAIT);
    checkOutput("wrLatency", 32'(cycles - 1), 32'(WR_LAT));
    refMem[wordOf(addr)]   = data;
    refKnown[wordOf(addr)] = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, addr, 32'h0);
    tick();
    checkOutput("wrDoneDrop", {31'b0, Mem_write_done}, 32'd0);
    checkOutput("wrBusyDrop", {31'b0, Mem_busy}, 32'd0);
  endtask

  task automatic doRead(input logic [31:0] addr, input logic exclusive);
    int cycles;
    bit known;
    logic [31:0] expVal;
    expectedRead(addr, known, expVal);
    applyStimulus(~exclusive, exclusive, 1'b0, 1'b0, addr, 32'h0);
    cycles = 0;
    do begin
      tick();
      cycles++;
    end while (!Data_in_Bus && cycles < MAX_WAIT);
    checkOutput("rdLatency", 32'(cycles - 1), 32'(RD_LAT));
    checkOutput("rdOe", {31'b0, Data_Bus_Com_oe}, 32'd1);
    if (known) checkOutput("rdData", Data_Bus_Com_out, expVal);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, addr, 32'h0);
    tick();
    checkOutput("rdValidDrop", {31'b0, Data_in_Bus}, 32'd0);
    checkOutput("rdOeDrop", {31'b0, Data_Bus_Com_oe}, 32'd0);
    checkOutput("rdBusyDrop", {31'b0, Mem_busy}, 32'd0);
  endtask

  initial begin
    int cycles;
    int sawData;
    logic [31:0] addr;
    logic [31:0] data;
    bit known;
    logic [31:0] expVal;

    for (int i = 0; i < WORDS; i++) refKnown[i] = 1'b0;

    // Reset: every output low.
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    tick();
    rst = 1'b0;
    modelReset();
    checkOutput("rstOut", Data_Bus_Com_out, 32'h0);
    checkOutput("rstOe", {31'b0, Data_Bus_Com_oe}, 32'd0);
    checkOutput("rstValid", {31'b0, Data_in_Bus}, 32'd0);
    checkOutput("rstDone", {31'b0, Mem_write_done}, 32'd0);
    checkOutput("rstBusy", {31'b0, Mem_busy}, 32'd0);
    tick();

    // Write then read back.
    $display("[TB] write then read");
    doWrite(32'h0000_0040, 32'hDEAD_BEEF, 1'b0);
    doRead(32'h0000_0040, 1'b0);

    // Abort two cycles after accepting a BusRdX.
    $display("[TB] read abort");
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0040, 32'h0);
    tick();
    tick();
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0040, 32'h0);
    tick();
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0040, 32'h0);
    sawData = 0;
    for (int i = 0; i < 8; i++) begin
      if (Data_in_Bus) sawData++;
      tick();
    end
    checkOutput("abortNoData", 32'(sawData), 32'd0);
    checkOutput("abortBusyHeld", {31'b0, Mem_busy}, 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    checkOutput("abortBusyDrop", {31'b0, Mem_busy}, 32'd0);
    tick();

    // Simultaneous write and read: write is served first.
    $display("[TB] simultaneous requests");
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0080, 32'hA5A5_5A5A);
    cycles = 0;
    do begin
      tick();
      cycles++;
    end while (!Mem_write_done && cycles < MAX_WAIT);
    checkOutput("simWrLatency", 32'(cycles - 1), 32'(WR_LAT));
    checkOutput("simNoRead", {31'b0, Data_in_Bus}, 32'd0);
    refMem[wordOf(32'h0000_0080)]   = 32'hA5A5_5A5A;
    refKnown[wordOf(32'h0000_0080)] = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0080, 32'h0);
    cycles = 0;
    do begin
      tick();
      cycles++;
    end while (!Data_in_Bus && cycles < MAX_WAIT);
    checkOutput("simRdLatency", 32'(cycles), 32'(RD_LAT + 2));
    checkOutput("simRdData", Data_Bus_Com_out, 32'hA5A5_5A5A);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    checkOutput("simBusyDrop", {31'b0, Mem_busy}, 32'd0);

    // Abort is ignored by write-backs.
    $display("[TB] abort during write");
    doWrite(32'h0000_00C0, 32'h1111_2222, 1'b1);
    doRead(32'h0000_00C0, 1'b1);

    // Reset during WR_WAIT drops the write.
    $display("[TB] reset mid-write");
    doWrite(32'h0000_0100, 32'hCAFE_F00D, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0100, 32'h0BAD_BEEF);
    tick();
    tick();
    rst = 1'b1;
    tick();
    checkOutput("midRstOut", Data_Bus_Com_out, 32'h0);
    checkOutput("midRstOe", {31'b0, Data_Bus_Com_oe}, 32'd0);
    checkOutput("midRstValid", {31'b0, Data_in_Bus}, 32'd0);
    checkOutput("midRstDone", {31'b0, Mem_write_done}, 32'd0);
    checkOutput("midRstBusy", {31'b0, Mem_busy}, 32'd0);
    rst = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    modelReset();
    tick();
    doRead(32'h0000_0100, 1'b0);

    // Address aliasing, plus init pattern for a never-written word.
    $display("[TB] aliasing");
`ifdef SHARED_MEM_INIT_PATTERN_EN
    doRead(32'h1000_0104, 1'b0);
`endif
    doWrite(32'h0000_0104, 32'h1234_5678, 1'b0);
    doRead(32'h1000_0104, 1'b0);

    // Randomized traffic over a small set of words with random alias bits.
    $display("[TB] random traffic");
    for (int n = 0; n < 40; n++) begin
      addr = ($urandom() & 32'hFFFF_F000) | (32'($urandom_range(0, 7)) << 2)
             | 32'($urandom_range(0, 3));
      expectedRead(addr, known, expVal);
      if (!known || $urandom_range(0, 1) == 0) begin
        data = $urandom();
        doWrite(addr, data, 1'($urandom_range(0, 1)));
      end else begin
        doRead(addr, 1'($urandom_range(0, 1)));
      end
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
